// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b types plus memory-sequencer state and lane mask
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [7:0]  lc3b_byte;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LDB  = 4'b0010,
        OP_STB  = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_SHF  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } lc3b_opcode;

    typedef enum logic [1:0] {
        MS_FIRST  = 2'b00,
        MS_SECOND = 2'b01,
        MS_HOLD   = 2'b10
    } lc3b_memseq_state;

    function automatic logic is_mem_opcode(input lc3b_opcode op);
        return (op == OP_LDR) || (op == OP_LDB) || (op == OP_LDI) ||
               (op == OP_STR) || (op == OP_STB) || (op == OP_STI);
    endfunction

    function automatic logic is_load_opcode(input lc3b_opcode op);
        return (op == OP_LDR) || (op == OP_LDB) || (op == OP_LDI);
    endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// rtl/mem_lane_steer.sv - byte-lane steering for stores and load formatting
module mem_lane_steer
    import lc3b_types::*;
(
    input  lc3b_opcode    opcode,
    input  logic          addr0,
    input  lc3b_word      store_data,
    input  lc3b_word      rdata,
    output lc3b_mem_wmask byte_enable,
    output lc3b_word      wdata,
    output lc3b_word      load_fmt
);

    lc3b_byte sel_byte;

    // Store lanes: STB mirrors the byte onto both lanes and enables only the addressed one
    always_comb begin
        byte_enable = 2'b11;
        wdata       = store_data;
        if (opcode == OP_STB) begin
            wdata       = {store_data[7:0], store_data[7:0]};
            byte_enable = addr0 ? 2'b10 : 2'b01;
        end
    end

    // Load format: LDB zero-extends the addressed byte, word loads pass through
    always_comb begin
        sel_byte = addr0 ? rdata[15:8] : rdata[7:0];
        load_fmt = rdata;
        if (opcode == OP_LDB) begin
            load_fmt = {8'h00, sel_byte};
        end
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - MEM-stage data port sequencer; MEM_INDIRECT_EN enables two-phase LDI/STI
module mem_access_sequencer
    import lc3b_types::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_valid,
    input  lc3b_opcode    opcode,
    input  lc3b_word      address,
    input  lc3b_word      store_data,
    input  logic          load_mem,
    input  lc3b_word      mem_rdata_b,
    input  logic          mem_resp_b,
    output logic          mem_read_b,
    output logic          mem_write_b,
    output lc3b_word      mem_address_b,
    output lc3b_word      mem_wdata_b,
    output lc3b_mem_wmask mem_byte_enable_b,
    output logic          ldi_sig,
    output lc3b_word      load_data
);

    lc3b_memseq_state state_q, state_d;
    lc3b_word         hold_q, hold_d;
`ifdef MEM_INDIRECT_EN
    lc3b_word         ptr_q, ptr_d;
`endif

    lc3b_mem_wmask steer_be;
    lc3b_word      steer_wdata;
    lc3b_word      steer_load;

    logic     mem_op;
    logic     indirect;
    logic     load_op;
    logic     byte_op;
    lc3b_word word_addr;

    logic          rd, wr, ldi;
    lc3b_word      addr, wdat, ldat;
    lc3b_mem_wmask be;

    mem_lane_steer u_steer (
        .opcode      (opcode),
        .addr0       (address[0]),
        .store_data  (store_data),
        .rdata       (mem_rdata_b),
        .byte_enable (steer_be),
        .wdata       (steer_wdata),
        .load_fmt    (steer_load)
    );

    // Instruction decode shared by every state
    always_comb begin
        mem_op    = mem_valid && is_mem_opcode(opcode);
        load_op   = is_load_opcode(opcode);
        byte_op   = (opcode == OP_LDB) || (opcode == OP_STB);
        word_addr = {address[15:1], 1'b0};
`ifdef MEM_INDIRECT_EN
        indirect  = mem_op && ((opcode == OP_LDI) || (opcode == OP_STI));
`else
        indirect  = 1'b0;
`endif
    end

    // Next state and request generation; everything forced quiet while reset is high
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
`ifdef MEM_INDIRECT_EN
        ptr_d   = ptr_q;
`endif
        rd   = 1'b0;
        wr   = 1'b0;
        ldi  = 1'b0;
        addr = 16'h0000;
        wdat = 16'h0000;
        be   = 2'b00;
        ldat = 16'h0000;

        case (state_q)
            MS_FIRST: begin
                if (mem_op) begin
                    if (indirect) begin
                        rd   = 1'b1;
                        ldi  = 1'b1;
                        addr = word_addr;
                        if (mem_resp_b) begin
`ifdef MEM_INDIRECT_EN
                            ptr_d   = mem_rdata_b;
`endif
                            state_d = MS_SECOND;
                        end
                    end else begin
                        addr = byte_op ? address : word_addr;
                        if (load_op) begin
                            rd = 1'b1;
                        end else begin
                            wr   = 1'b1;
                            wdat = steer_wdata;
                            be   = steer_be;
                        end
                        if (mem_resp_b) begin
                            if (load_op) begin
                                ldat   = steer_load;
                                hold_d = steer_load;
                            end
                            state_d = load_mem ? MS_FIRST : MS_HOLD;
                        end
                    end
                end
            end
`ifdef MEM_INDIRECT_EN
            MS_SECOND: begin
                addr = {ptr_q[15:1], 1'b0};
                if (opcode == OP_LDI) begin
                    rd = 1'b1;
                end else begin
                    wr   = 1'b1;
                    wdat = steer_wdata;
                    be   = steer_be;
                end
                if (mem_resp_b) begin
                    if (opcode == OP_LDI) begin
                        ldat   = steer_load;
                        hold_d = steer_load;
                    end
                    state_d = load_mem ? MS_FIRST : MS_HOLD;
                end
            end
`endif
            MS_HOLD: begin
                ldat = hold_q;
                if (load_mem) begin
                    state_d = MS_FIRST;
                end
            end
            default: begin
                state_d = MS_FIRST;
            end
        endcase

        if (reset) begin
            rd   = 1'b0;
            wr   = 1'b0;
            ldi  = 1'b0;
            addr = 16'h0000;
            wdat = 16'h0000;
            be   = 2'b00;
            ldat = 16'h0000;
        end
    end

    // State, hold and pointer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MS_FIRST;
            hold_q  <= 16'h0000;
`ifdef MEM_INDIRECT_EN
            ptr_q   <= 16'h0000;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
`ifdef MEM_INDIRECT_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign mem_read_b        = rd;
    assign mem_write_b       = wr;
    assign mem_address_b     = addr;
    assign mem_wdata_b       = wdat;
    assign mem_byte_enable_b = be;
    assign ldi_sig           = ldi;
    assign load_data         = ldat;

endmodule
